// File: rtl/read_tile_sequencer.sv
// Issues one AR per burst of a strided read job to the HBM read bridge, gating each burst on consumer credits.
// Latency: 2 cycles from accept to first ctrl_arvalid and from rlast to next ctrl_arvalid.
// Backpressure: cmd_ready only in IDLE; AR held until ctrl_arready. READ_SEQ_PERF_EN enables the perf counters.
module read_tile_sequencer #(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int CREDIT_DEPTH       = 256
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_base_addr,
  input  logic [15:0]                   cmd_num_bursts,
  input  logic [7:0]                    cmd_arlen,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_stride,
  output logic                          ctrl_arvalid,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_araddr,
  output logic [7:0]                    ctrl_arlen,
  input  logic                          ctrl_arready,
  input  logic                          ctrl_rvalid,
  input  logic                          ctrl_rlast,
  input  logic                          credit_return,
  output logic                          busy,
  output logic                          done,
  output logic                          err_len,
  output logic                          err_credit,
  output logic [31:0]                   perf_stall_cycles,
  output logic [31:0]                   perf_beats
);
  localparam int CW = $clog2(CREDIT_DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(CREDIT_DEPTH);

  typedef enum logic [2:0] {IDLE, WAIT_CREDIT, ADDR, DATA, DONE} state_t;

  state_t                        state;
  logic [C_M_AXI_ADDR_WIDTH-1:0] cur_addr;
  logic [C_M_AXI_ADDR_WIDTH-1:0] stride;
  logic [15:0]                   bursts_left;
  logic [7:0]                    arlen;
  logic [7:0]                    beat_cnt;
  logic [CW-1:0]                 credits;
  logic [CW-1:0]                 need;
  logic                          accept;
  logic                          ar_hs;
  logic                          credit_ok;
  logic                          len_too_big;

  assign accept      = (state == IDLE) && cmd_valid && cmd_ready;
  assign ar_hs       = (state == ADDR) && ctrl_arready;
  assign need        = CW'({1'b0, arlen} + 9'd1);
  assign credit_ok   = credits >= need;
  assign len_too_big = (32'(cmd_arlen) + 32'd1) > 32'(CREDIT_DEPTH);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      cmd_ready    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_len      <= 1'b0;
      ctrl_arvalid <= 1'b0;
      ctrl_araddr  <= '0;
      ctrl_arlen   <= '0;
      cur_addr     <= '0;
      stride       <= '0;
      bursts_left  <= '0;
      arlen        <= '0;
      beat_cnt     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (accept) begin
            cmd_ready   <= 1'b0;
            busy        <= 1'b1;
            err_len     <= 1'b0;
            cur_addr    <= cmd_base_addr;
            stride      <= cmd_stride;
            arlen       <= cmd_arlen;
            bursts_left <= cmd_num_bursts;
            if (cmd_num_bursts == 16'd0) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (len_too_big) begin
              err_len <= 1'b1;
              state   <= DONE;
              done    <= 1'b1;
            end else begin
              state <= WAIT_CREDIT;
            end
          end
        end
        WAIT_CREDIT: begin
          if (credit_ok) begin
            state        <= ADDR;
            ctrl_arvalid <= 1'b1;
            ctrl_araddr  <= cur_addr;
            ctrl_arlen   <= arlen;
          end
        end
        ADDR: begin
          if (ctrl_arready) begin
            ctrl_arvalid <= 1'b0;
            cur_addr     <= cur_addr + stride;
            bursts_left  <= bursts_left - 16'd1;
            beat_cnt     <= '0;
            state        <= DATA;
          end
        end
        DATA: begin
          if (ctrl_rvalid) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (ctrl_rlast) begin
              // beat_cnt still holds the index of this beat, so a full burst ends at arlen
              if (beat_cnt != arlen) err_len <= 1'b1;
              if (bursts_left == 16'd0) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state <= WAIT_CREDIT;
              end
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A return coinciding with the AR handshake always nets, even at full credits
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      credits    <= FULL;
      err_credit <= 1'b0;
    end else begin
      if (accept) err_credit <= 1'b0;
      if (ar_hs) begin
        credits <= credits - need + CW'(credit_return);
      end else if (credit_return) begin
        if (credits == FULL) err_credit <= 1'b1;
        else                 credits    <= credits + CW'(1);
      end
    end
  end

`ifdef READ_SEQ_PERF_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_stall_cycles <= '0;
      perf_beats        <= '0;
    end else if (accept) begin
      perf_stall_cycles <= '0;
      perf_beats        <= '0;
    end else begin
      if (state == WAIT_CREDIT && !credit_ok && perf_stall_cycles != '1)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (state == DATA && ctrl_rvalid && perf_beats != '1)
        perf_beats <= perf_beats + 32'd1;
    end
  end
`else
  assign perf_stall_cycles = '0;
  assign perf_beats        = '0;
`endif

endmodule

// File: tb/tb_read_tile_sequencer.sv
// Randomized bench for read_tile_sequencer: the bench plays bridge and consumer and predicts
// AR addresses, burst timing from a credit count, error flags and perf counts.
module tb_read_tile_sequencer;
  localparam int AW = 64;
  localparam int D  = 16;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_base_addr = '0;
  logic [15:0]   cmd_num_bursts = '0;
  logic [7:0]    cmd_arlen = '0;
  logic [AW-1:0] cmd_stride = '0;
  logic          ctrl_arvalid;
  logic [AW-1:0] ctrl_araddr;
  logic [7:0]    ctrl_arlen;
  logic          ctrl_arready = 1'b0;
  logic          ctrl_rvalid = 1'b0;
  logic          ctrl_rlast = 1'b0;
  logic          credit_return = 1'b0;
  logic          busy, done, err_len, err_credit;
  logic [31:0]   perf_stall_cycles, perf_beats;

  always #5 clk = ~clk;

  read_tile_sequencer #(.C_M_AXI_ADDR_WIDTH(AW), .CREDIT_DEPTH(D)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_base_addr(cmd_base_addr), .cmd_num_bursts(cmd_num_bursts),
    .cmd_arlen(cmd_arlen), .cmd_stride(cmd_stride),
    .ctrl_arvalid(ctrl_arvalid), .ctrl_araddr(ctrl_araddr), .ctrl_arlen(ctrl_arlen),
    .ctrl_arready(ctrl_arready), .ctrl_rvalid(ctrl_rvalid), .ctrl_rlast(ctrl_rlast),
    .credit_return(credit_return), .busy(busy), .done(done),
    .err_len(err_len), .err_credit(err_credit),
    .perf_stall_cycles(perf_stall_cycles), .perf_beats(perf_beats)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Consumer model: free entries plus entries reserved/in use always sum to D
  int cred     = D;
  int pending  = 0;
  int cr_hold  = 0;
  int need_cur = 1;
  bit force_cr = 0;
  bit net_cr   = 0;
  bit err_c_exp = 0;
  bit aborted  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Drives this cycle's credit_return, updates the model for the coming edge, then advances one cycle
  task automatic tick();
    bit hs, cr;
    hs = ctrl_arready;
    cr = 0;
    if (hs) pending += need_cur;
    if (force_cr) cr = 1;
    else if (hs && net_cr) begin cr = 1; pending--; end
    else if (cr_hold > 0) cr_hold--;
    else if (pending > 0 && $urandom_range(0, 1) == 1) begin cr = 1; pending--; end
    credit_return = cr;
    if (cmd_valid && cmd_ready) err_c_exp = 0;
    if (hs) cred = cred - need_cur + int'(cr);
    else if (cr) begin
      if (cred == D) err_c_exp = 1;
      else cred++;
    end
    @(posedge clk);
    @(negedge clk);
    credit_return = 1'b0;
    force_cr = 0;
  endtask

  task automatic stray();
    ctrl_rvalid = ($urandom_range(0, 3) == 0);
    ctrl_rlast  = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int guard = 0;
    while ((pending > 0 || cr_hold > 0) && !aborted) begin
      tick();
      if (++guard > 400) begin check_eq("drain_timeout", 0, 1); aborted = 1; end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_cmd_ready"}, cmd_ready, 0);
    check_eq({tag, "_arvalid"}, ctrl_arvalid, 0);
    check_eq({tag, "_araddr"}, ctrl_araddr, 0);
    check_eq({tag, "_arlen"}, ctrl_arlen, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_err_len"}, err_len, 0);
    check_eq({tag, "_err_credit"}, err_credit, 0);
    check_eq({tag, "_perf_stall"}, perf_stall_cycles, 0);
    check_eq({tag, "_perf_beats"}, perf_beats, 0);
  endtask

  task automatic do_reset();
    #2 resetn = 1'b0;
    #1 check_reset_outputs("midreset");
    cmd_valid = 0; ctrl_arready = 0; ctrl_rvalid = 0; ctrl_rlast = 0; credit_return = 0;
    cred = D; pending = 0; cr_hold = 0; force_cr = 0; net_cr = 0; err_c_exp = 0;
    @(negedge clk);
    resetn = 1'b1;
    check_eq("cmd_ready_in_release", cmd_ready, 0);
    @(negedge clk);
    check_eq("cmd_ready_after_release", cmd_ready, 1);
  endtask

  task automatic run_job(input logic [63:0] base, input int nb, input int len,
                         input logic [63:0] stride, input int short_b, input int short_n,
                         input int rst_beat);
    logic [63:0] addr;
    int  exp_stall, exp_beats, guard, nbeats, ps, pb;
    bit  exp_el, early, go, hs;
    if (aborted) return;
    exp_stall = 0; exp_beats = 0;
    early  = (nb == 0) || (len + 1 > D);
    exp_el = (nb != 0) && (len + 1 > D);
    check_eq("cmd_ready_idle", cmd_ready, 1);
    cmd_valid      = 1'b1;
    cmd_base_addr  = base;
    cmd_num_bursts = 16'(nb);
    cmd_arlen      = 8'(len);
    cmd_stride     = stride;
    need_cur       = len + 1;
    tick();
    cmd_valid      = 1'b0;
    cmd_base_addr  = {$urandom, $urandom};
    cmd_num_bursts = 16'($urandom);
    cmd_arlen      = 8'($urandom);
    cmd_stride     = {$urandom, $urandom};
    check_eq("busy_after_accept", busy, 1);
    check_eq("cmd_ready_after_accept", cmd_ready, 0);
    check_eq("err_len_after_accept", err_len, exp_el);
    check_eq("err_credit_after_accept", err_credit, err_c_exp);
    addr = base;
    for (int b = 0; b < nb && !early; b++) begin
      go = 0; guard = 0;
      while (!go) begin
        check_eq("arvalid_while_waiting", ctrl_arvalid, 0);
        if (cred >= need_cur) go = 1; else exp_stall++;
        stray();
        tick();
        if (++guard > 500) begin check_eq("credit_wait_timeout", 0, 1); aborted = 1; return; end
      end
      hs = 0; guard = 0;
      while (!hs) begin
        check_eq("arvalid", ctrl_arvalid, 1);
        check_eq("araddr", ctrl_araddr, addr);
        check_eq("arlen", ctrl_arlen, 64'(len));
        ctrl_arready = ($urandom_range(0, 2) != 0);
        hs = ctrl_arready;
        stray();
        tick();
        ctrl_arready = 1'b0;
        if (++guard > 100) begin check_eq("arready_loop_timeout", 0, 1); aborted = 1; return; end
      end
      ctrl_rvalid = 0; ctrl_rlast = 0;
      check_eq("arvalid_drop", ctrl_arvalid, 0);
      addr   = addr + stride;
      nbeats = (b == short_b) ? short_n : need_cur;
      if (nbeats != need_cur) exp_el = 1;
      for (int k = 0; k < nbeats; ) begin
        if (b == 0 && k == rst_beat) begin do_reset(); return; end
        ctrl_rvalid = ($urandom_range(0, 3) != 0);
        ctrl_rlast  = ctrl_rvalid && (k == nbeats - 1);
        if (ctrl_rvalid) begin k++; exp_beats++; end
        tick();
      end
      ctrl_rvalid = 0; ctrl_rlast = 0;
    end
`ifdef READ_SEQ_PERF_EN
    ps = exp_stall; pb = exp_beats;
`else
    ps = 0; pb = 0;
`endif
    check_eq("done_pulse", done, 1);
    check_eq("busy_in_done", busy, 1);
    check_eq("err_len_at_done", err_len, exp_el);
    check_eq("err_credit_at_done", err_credit, err_c_exp);
    check_eq("perf_stall_at_done", perf_stall_cycles, 64'(ps));
    check_eq("perf_beats_at_done", perf_beats, 64'(pb));
    tick();
    check_eq("done_one_cycle", done, 0);
    check_eq("cmd_ready_after_done", cmd_ready, 1);
    check_eq("busy_after_done", busy, 0);
    check_eq("err_len_sticky", err_len, exp_el);
    check_eq("perf_stall_hold", perf_stall_cycles, 64'(ps));
    check_eq("perf_beats_hold", perf_beats, 64'(pb));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1);
  end

  initial begin
    int nb, len, sb, sn;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    resetn = 1'b1;
    @(negedge clk);
    check_eq("cmd_ready_after_reset", cmd_ready, 1);

    run_job(64'h1000, 3, 3, 64'h400, -1, 0, -1);

    drain();
    cr_hold = 40;
    run_job(64'h2000, 2, D - 1, 64'h100, -1, 0, -1);

    run_job(64'h3000, 0, 3, 64'h40, -1, 0, -1);
    run_job(64'h3100, 1, D, 64'h40, -1, 0, -1);
    run_job(64'h3200, 4, 255, 64'h40, -1, 0, -1);

    run_job(64'h5000, 3, 3, 64'h80, 1, 2, -1);
    run_job(64'h5800, 1, 0, 64'h80, -1, 0, -1);

    drain();
    if (!aborted) begin
      force_cr = 1;
      tick();
      check_eq("err_credit_set", err_credit, 1);
      tick();
      check_eq("err_credit_sticky", err_credit, 1);
    end

    drain();
    cr_hold = 100000;
    net_cr  = 1;
    run_job(64'h6000, 5, 3, 64'h20, -1, 0, -1);
    net_cr  = 0;
    cr_hold = 0;
    drain();

    run_job(64'hFFFF_FFFF_FFFF_FC00, 2, 3, 64'h400, -1, 0, -1);

    run_job(64'h7000, 3, 3, 64'h10, -1, 0, 1);
    run_job(64'h7100, 1, D - 1, 64'h10, -1, 0, -1);

    for (int j = 0; j < 16; j++) begin
      nb  = $urandom_range(0, 5);
      len = ($urandom_range(0, 9) == 0) ? $urandom_range(D, 255) : $urandom_range(0, D - 1);
      sb  = -1; sn = 0;
      if (nb > 0 && len > 0 && $urandom_range(0, 3) == 0) begin
        sb = $urandom_range(0, nb - 1);
        sn = $urandom_range(1, len);
      end
      run_job({$urandom, $urandom}, nb, len, {$urandom, $urandom}, sb, sn, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
